bram_rw_sequencer: RTL and testbench
====================================

# bram_rw_sequencer
Controller that sequences one BRAM accessor job: a read pass of N words out of BRAM port A, then a write pass of N words into BRAM port B. It runs the accessor's IDLE/RUN/DONE handshake at job level. It sits between the host-side start/run_count registers and the dual-port BRAM. Read data streams out with no backpressure; write data is accepted through a valid/ready handshake.
## Interface
- CNT_BIT, 31: width of run_count_i and the internal counters
- AWIDTH, 12: BRAM address width
- DWIDTH, 32: BRAM data width
- RD_LAT, 2: BRAM read latency in cycles (≥1)
- clk  in  1  clock; one clock for the whole block
- reset  in  1  reset; synchronous, active-high
- start_i  in  1  job start pulse; sampled only in IDLE
- run_count_i  in  CNT_BIT  words per pass; captured when start is accepted
- idle_o / run_o / done_o  out  1 each  state flags; done_o is a 1-cycle pulse
- ce0_o  out  1  port A read enable
- addr0_o  out  AWIDTH  port A address
- q0_i  in  DWIDTH  port A read data
- rd_valid_o  out  1  read data valid
- rd_data_o  out  DWIDTH  read data (equals q0_i when rd_valid_o=1)
- wr_valid_i  in  1  write data valid
- wr_data_i  in  DWIDTH  write data
- wr_ready_o  out  1  write data accepted when valid&ready
- we1_o  out  1  port B enable+write strobe
- addr1_o  out  AWIDTH  port B address
- d1_o  out  DWIDTH  port B write data
- err_o  out  1  sticky start-while-busy flag (see Configuration)
## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE→READ on start_i when run_count_i≠0. The count is captured into cnt_val and rd_cnt/wr_cnt are cleared. IDLE→DONE on start_i when run_count_i=0; no BRAM access occurs.
- READ: ce0_o=1 every cycle, addr0_o=rd_cnt[AWIDTH-1:0], rd_cnt+1 per cycle. On the cycle with rd_cnt==cnt_val-1 (the last read), the next state is DRAIN.
- DRAIN: ce0_o=0. Stay RD_LAT cycles until the last read data is presented, then go to WRITE.
- WRITE: wr_ready_o=1. On each valid&ready: we1_o=1, addr1_o=wr_cnt[AWIDTH-1:0], d1_o=wr_data_i (combinational, same cycle), wr_cnt+1. On the handshake with wr_cnt==cnt_val-1, go to DONE.
- DONE: one cycle, then IDLE unconditionally.
- idle_o=(IDLE); run_o=(READ|DRAIN|WRITE); done_o=(DONE).
- Counters are CNT_BIT wide. Addresses are the low AWIDTH bits, so they wrap modulo 2^AWIDTH when run_count_i>2^AWIDTH.
- start_i outside IDLE is ignored; cnt_val is not recaptured.
## Timing
- Reset values: idle_o=1, all other outputs 0, addresses 0. The valid pipeline and counters are cleared.
- Reset asserted mid-job aborts the job. On the next cycle the block is in IDLE, with no done_o pulse and no further BRAM access.
- Read latency: rd_valid_o rises exactly RD_LAT cycles after the corresponding ce0_o. Read data is delivered in address order, back-to-back, N valid cycles total.
- READ lasts N cycles and DRAIN lasts RD_LAT cycles. The first wr_ready_o appears N+RD_LAT+1 cycles after start acceptance.
- Write side: one word per cycle maximum. Gaps in wr_valid_i stall WRITE indefinitely.
- done_o pulses the cycle after the last write handshake. A start_i in that DONE cycle is ignored. A start_i on the first IDLE cycle is accepted.
## Configuration
- BRAM_SEQ_ERR_EN defined:
  - err_o sets when start_i=1 in any state other than IDLE.
  - err_o stays set until reset or the next accepted start.
- BRAM_SEQ_ERR_EN undefined: err_o is tied to 0 and no error logic is synthesized.
## Structure
- Shared package bram_seq_pkg holds:
  - the 3-bit state encodings IDLE=0, READ=1, DRAIN=2, WRITE=3, DONE=4;
  - default width constants.
- Sub-module bram_rd_lat_pipe: an RD_LAT-deep valid shift register fed by ce0_o, producing rd_valid_o. It has a synchronous clear.
## Test plan
- Reset, then run_count_i=4, RD_LAT=2, wr_valid_i held 1:
  - reads at addr 0..3, rd_valid_o 2 cycles later;
  - writes at addr 0..3;
  - done_o once; total 4+2+4+1 cycles to DONE.
- run_count_i=0: done_o the cycle after start; ce0_o/we1_o never assert.
- Write stall: wr_valid_i toggles 1,0,0,1,… with run_count_i=3. Exactly 3 we1_o pulses at addr 0,1,2 with d1_o matching wr_data_i; done_o follows the 3rd handshake.
- Wrap: AWIDTH=2, run_count_i=6. addr0_o sequence is 0,1,2,3,0,1.
- reset asserted mid-WRITE after 2 writes: next cycle idle_o=1, we1_o=0, no done_o. A new start runs cleanly from address 0.
- BRAM_SEQ_ERR_EN: a start_i pulse during READ sets err_o; the job still completes normally; err_o clears on the next accepted start.

Source files
------------

// File: rtl/bram_seq_pkg.sv
// Shared state encodings and default widths for the BRAM read/write sequencer.
package bram_seq_pkg;

   localparam int CNT_BIT_DEF = 31;
   localparam int AWIDTH_DEF  = 12;
   localparam int DWIDTH_DEF  = 32;
   localparam int RD_LAT_DEF  = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } seq_state_e;

   // A job is "running" from the first read until the last write handshake.
   function automatic logic is_running(input seq_state_e st);
      is_running = (st == ST_READ) || (st == ST_DRAIN) || (st == ST_WRITE);
   endfunction

endpackage

// File: rtl/bram_rd_lat_pipe.sv
// Read-valid delay line: tracks each port A read enable through the BRAM read latency.
module bram_rd_lat_pipe
   import bram_seq_pkg::*;
#(
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic ce,
   output logic valid
);

   logic [RD_LAT-1:0] sr_r;

   // Shift the read enable one stage per cycle; a clear flushes in-flight reads.
   always_ff @(posedge clk) begin
      if (clr) begin
         sr_r <= '0;
      end else begin
         sr_r <= (sr_r << 1) | RD_LAT'(ce);
      end
   end

   assign valid = sr_r[RD_LAT-1];

endmodule

// File: rtl/bram_rw_sequencer.sv
// Job-level BRAM sequencer: N reads from port A, drain, then N writes to port B.
// Optional sticky start-while-busy flag enabled by defining BRAM_SEQ_ERR_EN.
module bram_rw_sequencer
   import bram_seq_pkg::*;
#(
   parameter int CNT_BIT = CNT_BIT_DEF,
   parameter int AWIDTH  = AWIDTH_DEF,
   parameter int DWIDTH  = DWIDTH_DEF,
   parameter int RD_LAT  = RD_LAT_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start_i,
   input  logic [CNT_BIT-1:0] run_count_i,
   output logic               idle_o,
   output logic               run_o,
   output logic               done_o,
   output logic               ce0_o,
   output logic [AWIDTH-1:0]  addr0_o,
   input  logic [DWIDTH-1:0]  q0_i,
   output logic               rd_valid_o,
   output logic [DWIDTH-1:0]  rd_data_o,
   input  logic               wr_valid_i,
   input  logic [DWIDTH-1:0]  wr_data_i,
   output logic               wr_ready_o,
   output logic               we1_o,
   output logic [AWIDTH-1:0]  addr1_o,
   output logic [DWIDTH-1:0]  d1_o,
   output logic               err_o
);

   localparam int DR_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [DR_W-1:0]    DR_MAX  = DR_W'(RD_LAT - 1);
   localparam logic [CNT_BIT-1:0] CNT_ONE = CNT_BIT'(1);

   seq_state_e         state_r;
   seq_state_e         state_s;
   logic [CNT_BIT-1:0] cnt_val_r;
   logic [CNT_BIT-1:0] rd_cnt_r;
   logic [CNT_BIT-1:0] wr_cnt_r;
   logic [DR_W-1:0]    drain_cnt_r;
   logic               wr_hs_s;
   logic               last_rd_s;
   logic               last_wr_s;
   logic               drain_end_s;
   logic               rd_valid_s;

   assign wr_hs_s     = (state_r == ST_WRITE) && wr_valid_i;
   assign last_rd_s   = (rd_cnt_r == (cnt_val_r - CNT_ONE));
   assign last_wr_s   = (wr_cnt_r == (cnt_val_r - CNT_ONE));
   assign drain_end_s = (drain_cnt_r == DR_MAX);

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_i) begin
               if (run_count_i != '0) begin
                  state_s = ST_READ;
               end else begin
                  state_s = ST_DONE;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_READ: begin
            if (last_rd_s) begin
               state_s = ST_DRAIN;
            end else begin
               state_s = ST_READ;
            end
         end
         ST_DRAIN: begin
            if (drain_end_s) begin
               state_s = ST_WRITE;
            end else begin
               state_s = ST_DRAIN;
            end
         end
         ST_WRITE: begin
            if (wr_hs_s && last_wr_s) begin
               state_s = ST_DONE;
            end else begin
               state_s = ST_WRITE;
            end
         end
         ST_DONE:  state_s = ST_IDLE;
         default:  state_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Job length capture and read/drain/write progress counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_val_r   <= '0;
         rd_cnt_r    <= '0;
         wr_cnt_r    <= '0;
         drain_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  cnt_val_r <= run_count_i;
                  rd_cnt_r  <= '0;
                  wr_cnt_r  <= '0;
               end
            end
            ST_READ: begin
               rd_cnt_r    <= rd_cnt_r + CNT_ONE;
               drain_cnt_r <= '0;
            end
            ST_DRAIN: drain_cnt_r <= drain_cnt_r + DR_W'(1);
            ST_WRITE: begin
               if (wr_hs_s) begin
                  wr_cnt_r <= wr_cnt_r + CNT_ONE;
               end
            end
            ST_DONE:  drain_cnt_r <= '0;
            default:  drain_cnt_r <= '0;
         endcase
      end
   end

   bram_rd_lat_pipe #(
      .RD_LAT (RD_LAT)
   ) u_rd_lat_pipe (
      .clk   (clk),
      .clr   (reset),
      .ce    (ce0_o),
      .valid (rd_valid_s)
   );

   assign idle_o     = (state_r == ST_IDLE);
   assign run_o      = is_running(state_r);
   assign done_o     = (state_r == ST_DONE);
   assign ce0_o      = (state_r == ST_READ);
   assign addr0_o    = rd_cnt_r[AWIDTH-1:0];
   assign rd_valid_o = rd_valid_s;
   assign rd_data_o  = rd_valid_s ? q0_i : '0;
   assign wr_ready_o = (state_r == ST_WRITE);
   assign we1_o      = wr_hs_s;
   assign addr1_o    = wr_cnt_r[AWIDTH-1:0];
   assign d1_o       = wr_hs_s ? wr_data_i : '0;

`ifdef BRAM_SEQ_ERR_EN
   logic err_r;

   // Sticky flag for a start that arrives while a job is in progress.
   always_ff @(posedge clk) begin
      if (reset) begin
         err_r <= 1'b0;
      end else if (start_i && (state_r != ST_IDLE)) begin
         err_r <= 1'b1;
      end else if (start_i) begin
         err_r <= 1'b0;
      end
   end

   assign err_o = err_r;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bram_rw_sequencer.sv
// Directed self-checking bench for bram_rw_sequencer (main instance plus a narrow-address instance).
module tb_bram_rw_sequencer;

   localparam int CNT_BIT = 31;
   localparam int AW      = 12;
   localparam int DW      = 32;
   localparam int RL      = 2;

   logic clk = 1'b0;
   logic reset;
   logic start_i;
   logic [CNT_BIT-1:0] run_count_i;
   logic idle_o, run_o, done_o, ce0_o, rd_valid_o, wr_ready_o, we1_o, err_o;
   logic [AW-1:0] addr0_o, addr1_o;
   logic [DW-1:0] q0_i, rd_data_o, d1_o, wr_data_i;
   logic wr_valid_i;
   logic [DW-1:0] q_stage;

   logic w_start, w_idle, w_run, w_done, w_ce0, w_rd_valid, w_valid, w_ready, w_we1, w_err;
   logic [CNT_BIT-1:0] w_count;
   logic [1:0] w_addr0, w_addr1;
   logic [7:0] w_q0, w_rd_data, w_wdata, w_d1;

   int checks = 0;
   int failures = 0;

   int rd_addr_q[$], rd_cyc_q[$], rdv_cyc_q[$], wr_addr_q[$], wr_cyc_q[$], done_q[$];
   logic [DW-1:0] rd_data_q[$], wr_d_q[$];
   int first_rdy;
   logic err_at1;

   always #5 clk = ~clk;

   bram_rw_sequencer #(.CNT_BIT(CNT_BIT), .AWIDTH(AW), .DWIDTH(DW), .RD_LAT(RL)) dut (
      .clk(clk), .reset(reset), .start_i(start_i), .run_count_i(run_count_i),
      .idle_o(idle_o), .run_o(run_o), .done_o(done_o),
      .ce0_o(ce0_o), .addr0_o(addr0_o), .q0_i(q0_i),
      .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o),
      .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
      .we1_o(we1_o), .addr1_o(addr1_o), .d1_o(d1_o), .err_o(err_o)
   );

   bram_rw_sequencer #(.CNT_BIT(CNT_BIT), .AWIDTH(2), .DWIDTH(8), .RD_LAT(1)) u_wrap (
      .clk(clk), .reset(reset), .start_i(w_start), .run_count_i(w_count),
      .idle_o(w_idle), .run_o(w_run), .done_o(w_done),
      .ce0_o(w_ce0), .addr0_o(w_addr0), .q0_i(w_q0),
      .rd_valid_o(w_rd_valid), .rd_data_o(w_rd_data),
      .wr_valid_i(w_valid), .wr_data_i(w_wdata), .wr_ready_o(w_ready),
      .we1_o(w_we1), .addr1_o(w_addr1), .d1_o(w_d1), .err_o(w_err)
   );

   // BRAM read models: two-cycle latency for the main DUT, one cycle for the wrap DUT
   always @(posedge clk) begin
      q_stage <= ce0_o ? (32'hA5A5_0000 | DW'(addr0_o)) : 32'hDEAD_BEEF;
      q0_i    <= q_stage;
      w_q0    <= w_ce0 ? {6'd0, w_addr0} : 8'hFF;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic vpat(input int mode, input int c);
      if (mode == 1) vpat = ((c % 3) == 0);
      else           vpat = 1'b1;
   endfunction

   task automatic sample(input int c);
      if (ce0_o) begin rd_addr_q.push_back(int'(addr0_o)); rd_cyc_q.push_back(c); end
      if (rd_valid_o) begin rd_data_q.push_back(rd_data_o); rdv_cyc_q.push_back(c); end
      if (we1_o) begin wr_addr_q.push_back(int'(addr1_o)); wr_d_q.push_back(d1_o); wr_cyc_q.push_back(c); end
      if (wr_ready_o && first_rdy < 0) first_rdy = c;
      if (done_o) done_q.push_back(c);
      if (c == 1) err_at1 = err_o;
   endtask

   // Start a job on the next cycle (cycle 0) and run until done_o or the budget expires
   task automatic run_job(input logic [30:0] n, input int vmode, input int restart_cyc, input int budget);
      rd_addr_q.delete(); rd_cyc_q.delete(); rdv_cyc_q.delete(); rd_data_q.delete();
      wr_addr_q.delete(); wr_cyc_q.delete(); wr_d_q.delete(); done_q.delete();
      first_rdy = -1;
      err_at1 = 1'bx;
      @(posedge clk); #1;
      start_i = 1'b1; run_count_i = n; wr_valid_i = vpat(vmode, 0); wr_data_i = 32'hD000_0000;
      #1;
      checks++;
      if (idle_o !== 1'b1) begin failures++; $display("FAIL job_start_idle: idle_o=%b expected 1", idle_o); end
      sample(0);
      for (int c = 1; c <= budget; c++) begin
         @(posedge clk); #1;
         start_i = (c == restart_cyc);
         wr_valid_i = vpat(vmode, c);
         wr_data_i = 32'hD000_0000 + 32'(c);
         #1;
         sample(c);
         if (done_q.size() > 0) break;
      end
      checks++;
      if (done_q.size() == 0) begin failures++; $display("FAIL job_timeout: no done_o within %0d cycles", budget); end
   endtask

   task automatic test_reset();
      reset = 1'b1; start_i = 1'b0; run_count_i = '0; wr_valid_i = 1'b0; wr_data_i = '0;
      w_start = 1'b0; w_count = '0; w_valid = 1'b0; w_wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({idle_o, run_o, done_o, ce0_o, rd_valid_o, wr_ready_o, we1_o, err_o} !== 8'b1000_0000) begin
         failures++; $display("FAIL reset_flags: got %b expected 10000000",
            {idle_o, run_o, done_o, ce0_o, rd_valid_o, wr_ready_o, we1_o, err_o});
      end
      checks++;
      if (addr0_o !== 12'd0 || addr1_o !== 12'd0 || d1_o !== 32'd0 || rd_data_o !== 32'd0) begin
         failures++; $display("FAIL reset_buses: addr0=%0h addr1=%0h d1=%0h rd_data=%0h expected 0",
            addr0_o, addr1_o, d1_o, rd_data_o);
      end
      checks++;
      if (w_idle !== 1'b1) begin failures++; $display("FAIL reset_wrap_idle: got %b expected 1", w_idle); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      run_job(4, 0, -1, 30);
      checks++;
      if (rd_addr_q.size() != 4) begin failures++; $display("FAIL basic_rd_count: got %0d expected 4", rd_addr_q.size()); end
      for (int i = 0; i < rd_addr_q.size() && i < 4; i++) begin
         checks++;
         if (rd_addr_q[i] != i || rd_cyc_q[i] != 1 + i) begin
            failures++; $display("FAIL basic_rd_%0d: addr=%0d cyc=%0d expected addr=%0d cyc=%0d", i, rd_addr_q[i], rd_cyc_q[i], i, 1 + i);
         end
      end
      checks++;
      if (rd_data_q.size() != 4) begin failures++; $display("FAIL basic_rdv_count: got %0d expected 4", rd_data_q.size()); end
      for (int i = 0; i < rd_data_q.size() && i < 4; i++) begin
         checks++;
         if (rd_data_q[i] !== 32'hA5A5_0000 + 32'(i) || rdv_cyc_q[i] != 3 + i) begin
            failures++; $display("FAIL basic_rdv_%0d: data=%h cyc=%0d expected data=%h cyc=%0d",
               i, rd_data_q[i], rdv_cyc_q[i], 32'hA5A5_0000 + 32'(i), 3 + i);
         end
      end
      checks++;
      if (first_rdy != 7) begin failures++; $display("FAIL basic_first_ready: got %0d expected 7", first_rdy); end
      checks++;
      if (wr_addr_q.size() != 4) begin failures++; $display("FAIL basic_wr_count: got %0d expected 4", wr_addr_q.size()); end
      for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
         checks++;
         if (wr_addr_q[i] != i || wr_cyc_q[i] != 7 + i || wr_d_q[i] !== 32'hD000_0007 + 32'(i)) begin
            failures++; $display("FAIL basic_wr_%0d: addr=%0d cyc=%0d data=%h expected addr=%0d cyc=%0d data=%h",
               i, wr_addr_q[i], wr_cyc_q[i], wr_d_q[i], i, 7 + i, 32'hD000_0007 + 32'(i));
         end
      end
      checks++;
      if (done_q.size() != 1 || done_q[0] != 11) begin
         failures++; $display("FAIL basic_done_cycle: got %0d expected 11", (done_q.size() > 0) ? done_q[0] : -1);
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      #1;
      checks++;
      if (done_o !== 1'b0 || idle_o !== 1'b1) begin
         failures++; $display("FAIL basic_after_done: done=%b idle=%b expected done=0 idle=1", done_o, idle_o);
      end
   endtask

   task automatic test_zero_count();
      run_job(0, 0, -1, 10);
      checks++;
      if (done_q.size() != 1 || done_q[0] != 1) begin
         failures++; $display("FAIL zero_done_cycle: got %0d expected 1", (done_q.size() > 0) ? done_q[0] : -1);
      end
      checks++;
      if (rd_addr_q.size() != 0 || wr_addr_q.size() != 0 || rd_data_q.size() != 0 || first_rdy != -1) begin
         failures++; $display("FAIL zero_no_access: reads=%0d writes=%0d rdv=%0d ready_cyc=%0d expected 0 0 0 -1",
            rd_addr_q.size(), wr_addr_q.size(), rd_data_q.size(), first_rdy);
      end
   endtask

   task automatic test_write_stall();
      int exp_cyc[3];
      exp_cyc = '{6, 9, 12};
      run_job(3, 1, -1, 40);
      checks++;
      if (wr_addr_q.size() != 3) begin failures++; $display("FAIL stall_wr_count: got %0d expected 3", wr_addr_q.size()); end
      for (int i = 0; i < wr_addr_q.size() && i < 3; i++) begin
         checks++;
         if (wr_addr_q[i] != i || wr_cyc_q[i] != exp_cyc[i] || wr_d_q[i] !== 32'hD000_0000 + 32'(exp_cyc[i])) begin
            failures++; $display("FAIL stall_wr_%0d: addr=%0d cyc=%0d data=%h expected addr=%0d cyc=%0d data=%h",
               i, wr_addr_q[i], wr_cyc_q[i], wr_d_q[i], i, exp_cyc[i], 32'hD000_0000 + 32'(exp_cyc[i]));
         end
      end
      checks++;
      if (rd_data_q.size() != 3) begin failures++; $display("FAIL stall_rdv_count: got %0d expected 3", rd_data_q.size()); end
      checks++;
      if (done_q.size() != 1 || done_q[0] != 13) begin
         failures++; $display("FAIL stall_done_cycle: got %0d expected 13", (done_q.size() > 0) ? done_q[0] : -1);
      end
   endtask

   task automatic test_back_to_back();
      run_job(2, 0, -1, 20);
      checks++;
      if (done_q.size() != 1 || done_q[0] != 7) begin
         failures++; $display("FAIL b2b_first_done: got %0d expected 7", (done_q.size() > 0) ? done_q[0] : -1);
      end
      // second job starts on the first IDLE cycle; a start during its DONE cycle is ignored
      run_job(1, 0, 5, 20);
      checks++;
      if (rd_addr_q.size() != 1 || rd_cyc_q[0] != 1 || rd_addr_q[0] != 0) begin
         failures++; $display("FAIL b2b_second_read: reads=%0d expected 1 at cycle 1 addr 0", rd_addr_q.size());
      end
      checks++;
      if (wr_addr_q.size() != 1 || wr_cyc_q[0] != 4 || done_q[0] != 5) begin
         failures++; $display("FAIL b2b_second_write: writes=%0d done=%0d expected 1 write at cycle 4, done 5",
            wr_addr_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
      end
      @(posedge clk); #1;
      start_i = 1'b0;
      #1;
      checks++;
      if (idle_o !== 1'b1 || ce0_o !== 1'b0 || run_o !== 1'b0) begin
         failures++; $display("FAIL b2b_done_start_ignored: idle=%b ce0=%b run=%b expected 1 0 0", idle_o, ce0_o, run_o);
      end
      checks++;
`ifdef BRAM_SEQ_ERR_EN
      if (err_o !== 1'b1) begin failures++; $display("FAIL b2b_err_flag: got %b expected 1", err_o); end
`else
      if (err_o !== 1'b0) begin failures++; $display("FAIL b2b_err_flag: got %b expected 0", err_o); end
`endif
   endtask

   task automatic test_err_flag();
      run_job(4, 0, 2, 30);
      checks++;
      if (err_at1 !== 1'b0) begin failures++; $display("FAIL err_clear_on_start: got %b expected 0", err_at1); end
      checks++;
      if (rd_addr_q.size() != 4 || wr_addr_q.size() != 4 || done_q[0] != 11) begin
         failures++; $display("FAIL err_job_intact: reads=%0d writes=%0d done=%0d expected 4 4 11",
            rd_addr_q.size(), wr_addr_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
      end
      checks++;
`ifdef BRAM_SEQ_ERR_EN
      if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b expected 1", err_o); end
`else
      if (err_o !== 1'b0) begin failures++; $display("FAIL err_sticky: got %b expected 0", err_o); end
`endif
      run_job(1, 0, -1, 20);
      checks++;
      if (err_at1 !== 1'b0) begin failures++; $display("FAIL err_clear_next_job: got %b expected 0", err_at1); end
   endtask

   task automatic test_wrap();
      int ra[$], wa[$], rdat[$];
      int exp_a[6];
      int done_c;
      exp_a = '{0, 1, 2, 3, 0, 1};
      done_c = -1;
      @(posedge clk); #1;
      w_start = 1'b1; w_count = 31'd6; w_valid = 1'b1; w_wdata = 8'h3C;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         w_start = 1'b0;
         #1;
         if (w_ce0) ra.push_back(int'(w_addr0));
         if (w_rd_valid) rdat.push_back(int'(w_rd_data));
         if (w_we1) wa.push_back(int'(w_addr1));
         if (w_done) begin done_c = c; break; end
      end
      checks++;
      if (ra.size() != 6 || wa.size() != 6 || rdat.size() != 6) begin
         failures++; $display("FAIL wrap_counts: reads=%0d writes=%0d rdv=%0d expected 6 6 6", ra.size(), wa.size(), rdat.size());
      end
      for (int i = 0; i < 6 && i < ra.size() && i < wa.size() && i < rdat.size(); i++) begin
         checks++;
         if (ra[i] != exp_a[i] || wa[i] != exp_a[i] || rdat[i] != exp_a[i]) begin
            failures++; $display("FAIL wrap_addr_%0d: rd=%0d wr=%0d data=%0d expected %0d", i, ra[i], wa[i], rdat[i], exp_a[i]);
         end
      end
      checks++;
      if (done_c != 14) begin failures++; $display("FAIL wrap_done_cycle: got %0d expected 14", done_c); end
      w_valid = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      int we_cnt;
      logic bad;
      we_cnt = 0;
      @(posedge clk); #1;
      start_i = 1'b1; run_count_i = 31'd4; wr_valid_i = 1'b1; wr_data_i = 32'h1111_0000;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         start_i = 1'b0;
         #1;
         if (we1_o) we_cnt++;
      end
      checks++;
      if (we_cnt != 2) begin failures++; $display("FAIL rstmid_writes_before: got %0d expected 2", we_cnt); end
      @(posedge clk); #1;
      reset = 1'b1; wr_valid_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0; wr_valid_i = 1'b1;
      #1;
      checks++;
      if (idle_o !== 1'b1 || we1_o !== 1'b0 || done_o !== 1'b0 || ce0_o !== 1'b0 || rd_valid_o !== 1'b0) begin
         failures++; $display("FAIL rstmid_after_reset: idle=%b we1=%b done=%b ce0=%b rdv=%b expected 1 0 0 0 0",
            idle_o, we1_o, done_o, ce0_o, rd_valid_o);
      end
      bad = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #2;
         if (we1_o || done_o || ce0_o || !idle_o) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin failures++; $display("FAIL rstmid_quiet: activity=%b expected 0", bad); end
      run_job(2, 0, -1, 20);
      checks++;
      if (rd_addr_q.size() != 2 || rd_addr_q[0] != 0 || rd_addr_q[1] != 1) begin
         failures++; $display("FAIL rstmid_restart_reads: count=%0d expected 2 at addr 0,1", rd_addr_q.size());
      end
      checks++;
      if (wr_addr_q.size() != 2 || wr_addr_q[0] != 0 || wr_addr_q[1] != 1 || done_q[0] != 7) begin
         failures++; $display("FAIL rstmid_restart_writes: count=%0d done=%0d expected 2 at addr 0,1 done 7",
            wr_addr_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_write_stall();
      test_back_to_back();
      test_err_flag();
      test_wrap();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
